// File: rtl/instr_fetch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | instr_fetch_pkg                                                          |
// | Shared types and constants for the instruction fetch stage.              |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
package instr_fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int OPC_W   = 7;
  localparam int PC_INC  = 4;

  // Opcode field values seen by the main control decoder
  localparam logic [OPC_W-1:0] OPC_RTYPE = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_LD    = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_SD    = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BEQ   = 7'b1100011;

  typedef enum logic [1:0] {
    ST_FETCH    = 2'd0,
    ST_WAIT_RSP = 2'd1,
    ST_DROP     = 2'd2
  } fetch_state_t;

  function automatic logic is_word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ifetch_pc_sel.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ifetch_pc_sel                                                            |
// | Next-PC selection: reset / redirect / +4 / hold, with target alignment   |
// | check. IFETCH_MISALIGN_CHECK_EN: misaligned targets are rejected and     |
// | flagged; otherwise the two low target bits are forced to zero.           |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module ifetch_pc_sel
  import instr_fetch_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            i_rst,
  input  logic            i_advance,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic [XLEN-1:0] o_next_pc,
  output logic            o_misalign_hit
);

  logic [XLEN-1:0] w_target;
  logic            w_bad;

`ifdef IFETCH_MISALIGN_CHECK_EN
  assign w_target = i_redirect_pc;
  assign w_bad    = i_redirect & ~is_word_aligned(i_redirect_pc[1:0]);
`else
  logic [1:0] w_unused_lsb;
  assign w_unused_lsb = i_redirect_pc[1:0];
  assign w_target     = {i_redirect_pc[XLEN-1:2], 2'b00};
  assign w_bad        = 1'b0;
`endif

  // Priority mux: reset, then redirect (a rejected target holds the PC), then advance
  always_comb begin
    o_next_pc = i_pc;
    if (i_rst) begin
      o_next_pc = RESET_PC;
    end else if (i_redirect) begin
      if (!w_bad) o_next_pc = w_target;
    end else if (i_advance) begin
      o_next_pc = i_pc + XLEN'(PC_INC);
    end
  end

  assign o_misalign_hit = w_bad;

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | instr_fetch                                                              |
// | Instruction fetch stage: PC, single-outstanding imem requests, one-entry |
// | output slot with valid/ready, branch redirect with in-flight flush.      |
// | Optional macro IFETCH_MISALIGN_CHECK_EN enables the sticky misalign flag.|
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = 64'h0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req_valid,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_req_ready,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [XLEN-1:0]    instr_pc,
  output logic [OPC_W-1:0]   opcode,
  output logic               misalign
);

  fetch_state_t       r_state;
  logic [XLEN-1:0]    r_pc;
  logic               r_instr_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [XLEN-1:0]    r_instr_pc;
  logic               r_misalign;

  logic [XLEN-1:0]    w_next_pc;
  logic               w_slot_free;
  logic               w_req_fire;
  logic               w_capture;
  logic               w_mis_hit;

  // A request is only issued when the slot is guaranteed empty by the time
  // its response can land, so a capture never collides with a held entry.
  assign w_slot_free    = ~r_instr_valid | instr_ready;
  assign imem_req_valid = ~rst & (r_state == ST_FETCH) & w_slot_free & ~r_misalign;
  assign imem_req_addr  = r_pc;
  assign w_req_fire     = imem_req_valid & imem_req_ready;
  assign w_capture      = (r_state == ST_WAIT_RSP) & imem_rsp_valid & ~redirect;

  ifetch_pc_sel #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_sel (
    .i_rst          (rst),
    .i_advance      (w_capture),
    .i_redirect     (redirect),
    .i_pc           (r_pc),
    .i_redirect_pc  (redirect_pc),
    .o_next_pc      (w_next_pc),
    .o_misalign_hit (w_mis_hit)
  );

  // FSM, PC and output slot; redirect outranks a same-cycle capture
  always_ff @(posedge clk) begin
    r_pc <= w_next_pc;
    if (rst) begin
      r_state       <= ST_FETCH;
      r_instr_valid <= 1'b0;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_misalign    <= 1'b0;
    end else begin
      if (w_mis_hit) r_misalign <= 1'b1;

      if (redirect) begin
        r_instr_valid <= 1'b0;
      end else if (w_capture) begin
        r_instr_valid <= 1'b1;
        r_instr       <= imem_rsp_data;
        r_instr_pc    <= r_pc;
      end else if (r_instr_valid && instr_ready) begin
        r_instr_valid <= 1'b0;
      end

      unique case (r_state)
        ST_FETCH: begin
          if (w_req_fire) r_state <= redirect ? ST_DROP : ST_WAIT_RSP;
        end
        ST_WAIT_RSP: begin
          if (imem_rsp_valid)  r_state <= ST_FETCH;
          else if (redirect)   r_state <= ST_DROP;
        end
        ST_DROP: begin
          // The response being waited for belongs to an abandoned request
          if (imem_rsp_valid) r_state <= ST_FETCH;
        end
        default: r_state <= ST_FETCH;
      endcase
    end
  end

  assign instr_valid = r_instr_valid;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign opcode      = r_instr[OPC_W-1:0];
  assign misalign    = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_instr_fetch                                                           |
// | Self-checking bench: memory model plus behavioural reference of the      |
// | fetch stage, directed scenarios followed by randomized traffic.          |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_instr_fetch;

  localparam logic [63:0] RST_PC = 64'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic [6:0]  opcode;
  logic        misalign;

  int checks   = 0;
  int failures = 0;

  instr_fetch #(.XLEN(64), .RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .opcode         (opcode),
    .misalign       (misalign)
  );

  always #5 clk = ~clk;

  // Reference: next PC to fetch, whether a request is in flight and whether
  // its answer is to be thrown away, and the decode-facing slot.
  logic [63:0] m_pc;
  bit          m_out, m_stale, m_sv, m_mis;
  logic [31:0] m_si;
  logic [63:0] m_spc;

  // Instruction memory: one outstanding request, fixed latency per request
  bit          mem_busy;
  int          mem_wait;
  logic [63:0] mem_addr;

  logic [63:0] dq[$];          // PCs handed to decode, in order
  bit          last_acc;
  logic [63:0] last_acc_addr;

  function automatic logic [31:0] memword(input logic [63:0] a);
    logic [6:0] opc;
    case (a[3:2])
      2'd0:    opc = 7'b0110011;
      2'd1:    opc = 7'b0000011;
      2'd2:    opc = 7'b0100011;
      default: opc = 7'b1100011;
    endcase
    if (a == 64'h0) return 32'h002081B3;
    return {a[26:2] ^ a[58:34], opc};
  endfunction

  function automatic logic [63:0] dq_at(input int i);
    if (i < dq.size()) return dq[i];
    return 64'hxxxx_xxxx_xxxx_xxxx;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_out = 0; m_stale = 0; m_sv = 0; m_mis = 0;
    m_si = '0; m_spc = '0;
    mem_busy = 0; mem_wait = 0; mem_addr = '0;
  endtask

  // One clock cycle: drive at negedge, compare 1 ns later, advance models at posedge
  task automatic step(input bit rdy, input bit rd, input logic [63:0] rp,
                      input bit qr, input int lat);
    bit          e_req, acc, rsp, take, accm, mis_rd;
    logic [31:0] rdata;
    logic [63:0] aaddr;
    @(negedge clk);
    instr_ready    = rdy;
    redirect       = rd;
    redirect_pc    = rp;
    imem_req_ready = qr;
    rsp            = mem_busy && (mem_wait == 0) && !rst;
    rdata          = rsp ? memword(mem_addr) : $urandom;
    imem_rsp_valid = rsp;
    imem_rsp_data  = rdata;
    #1;
    e_req = !rst && !m_out && !m_mis && (!m_sv || rdy);
    chk("req_valid", 64'(imem_req_valid), 64'(e_req));
    if (!rst) chk("req_addr", imem_req_addr, m_pc);
    chk("instr_valid", 64'(instr_valid), 64'(m_sv));
    if (m_sv) begin
      chk("instr", 64'(instr), 64'(m_si));
      chk("instr_pc", instr_pc, m_spc);
      chk("opcode", 64'(opcode), 64'(m_si[6:0]));
    end
    chk("misalign", 64'(misalign), 64'(m_mis));
    if (instr_valid && rdy && !rst) dq.push_back(instr_pc);
    acc      = imem_req_valid && qr;
    aaddr    = imem_req_addr;
    last_acc = acc;
    if (acc) last_acc_addr = aaddr;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (rsp) mem_busy = 0;
      else if (mem_busy) mem_wait--;
      if (acc) begin mem_busy = 1; mem_addr = aaddr; mem_wait = lat - 1; end

`ifdef IFETCH_MISALIGN_CHECK_EN
      mis_rd = rd && (rp[1:0] != 2'b00);
`else
      mis_rd = 0;
`endif
      take = rsp && m_out && !m_stale && !rd;
      accm = e_req && qr;
      if (rsp) begin m_out = 0; m_stale = 0; end
      else if (rd && m_out) m_stale = 1;
      if (accm) begin m_out = 1; m_stale = rd; end
      if (rd) m_sv = 0;
      else if (take) begin m_sv = 1; m_si = rdata; m_spc = m_pc; end
      else if (m_sv && rdy) m_sv = 0;
      if (rd) begin
        if (mis_rd) m_mis = 1;
        else m_pc = {rp[63:2], 2'b00};
      end else if (take) begin
        m_pc = m_pc + 64'd4;
      end
    end
    #1;
  endtask

  task automatic run_until(input int n, input int lat, input string nm);
    int base;
    int k;
    base = dq.size();
    k = 0;
    while (dq.size() < base + n && k < 40) begin
      step(1, 0, 64'h0, 1, lat);
      k++;
    end
    if (dq.size() < base + n) begin
      checks++; failures++;
      $display("FAIL %s timeout delivered=%0d required=%0d", nm, dq.size() - base, n);
    end
  endtask

  task automatic wait_acc(input int lat, input string nm);
    int k;
    k = 0;
    last_acc = 0;
    while (!last_acc && k < 10) begin
      step(1, 0, 64'h0, 1, lat);
      k++;
    end
    if (!last_acc) begin
      checks++; failures++;
      $display("FAIL %s timeout no request accepted", nm);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] h;
    int          mark;
    int          nacc;
    logic [63:0] rp;
    rst = 1; instr_ready = 0; redirect = 0; redirect_pc = '0;
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0;
    last_acc = 0; last_acc_addr = '0;
    model_reset();
    @(posedge clk);
    repeat (2) step(1, 0, 64'h0, 1, 1);

    // Reset state
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_instr_valid", 64'(instr_valid), 64'd0);
    chk("rst_instr", 64'(instr), 64'd0);
    chk("rst_instr_pc", instr_pc, 64'd0);
    chk("rst_misalign", 64'(misalign), 64'd0);
    chk("rst_pc", imem_req_addr, 64'h0);
    rst = 0;

    // Back-to-back fetch with 1-cycle memory
    dq.delete();
    step(1, 0, 64'h0, 1, 1);
    step(1, 0, 64'h0, 1, 1);
    step(0, 0, 64'h0, 1, 1);
    chk("t1_first_valid", 64'(instr_valid), 64'd1);
    chk("t1_first_instr", 64'(instr), 64'h002081B3);
    chk("t1_first_opcode", 64'(opcode), 64'h33);
    repeat (8) step(1, 0, 64'h0, 1, 1);
    chk("t1_pc0", dq_at(0), 64'h0);
    chk("t1_pc1", dq_at(1), 64'h4);
    chk("t1_pc2", dq_at(2), 64'h8);

    // Decode stall with a full slot
    mark = 0;
    while (!m_sv && mark < 10) begin step(0, 0, 64'h0, 1, 1); mark++; end
    h = m_spc;
    repeat (5) begin
      step(0, 0, 64'h0, 1, 1);
      chk("t2_hold_pc", instr_pc, h);
      chk("t2_no_req", 64'(last_acc), 64'd0);
    end
    mark = dq.size();
    run_until(2, 1, "t2_resume");
    chk("t2_held_out", dq_at(mark), h);
    chk("t2_next_pc", dq_at(mark + 1), h + 64'd4);

    // Redirect while waiting, response lands the following cycle
    wait_acc(2, "t3_acc");
    step(1, 1, 64'h100, 1, 2);
    chk("t3_flush", 64'(instr_valid), 64'd0);
    mark = dq.size();
    step(1, 0, 64'h0, 1, 2);
    chk("t3_dropped", 64'(instr_valid), 64'd0);
    wait_acc(1, "t3_reacc");
    chk("t3_req_addr", last_acc_addr, 64'h100);
    run_until(1, 1, "t3_deliver");
    chk("t3_first_pc", dq_at(mark), 64'h100);

    // Redirect in the same cycle as the response
    wait_acc(1, "t4_acc");
    step(1, 1, 64'h200, 1, 1);
    chk("t4_slot_empty", 64'(instr_valid), 64'd0);
    mark = dq.size();
    step(1, 0, 64'h0, 1, 1);
    chk("t4_slot_still_empty", 64'(instr_valid), 64'd0);
    chk("t4_req_addr", last_acc_addr, 64'h200);
    run_until(1, 1, "t4_deliver");
    chk("t4_first_pc", dq_at(mark), 64'h200);

    // PC wrap at the top of the address space
    step(1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 1);
    mark = dq.size();
    run_until(2, 1, "t5_wrap");
    chk("t5_top_pc", dq_at(mark), 64'hFFFF_FFFF_FFFF_FFFC);
    chk("t5_wrapped_pc", dq_at(mark + 1), 64'h0);

    // Randomized traffic, with one reset pulse in the middle
    for (int i = 0; i < 3000; i++) begin
      rst = (i == 1500 || i == 1501);
      if ($urandom_range(0, 1) == 0) rp = {54'h0, 8'($urandom_range(0, 255)), 2'b00};
      else rp = {$urandom, $urandom};
`ifdef IFETCH_MISALIGN_CHECK_EN
      rp[1:0] = 2'b00;
`endif
      step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, rp,
           $urandom_range(0, 3) != 0, $urandom_range(1, 3));
    end
    rst = 0;

    // Misaligned redirect target
    step(1, 1, 64'h102, 1, 1);
`ifdef IFETCH_MISALIGN_CHECK_EN
    chk("t6_misalign", 64'(misalign), 64'd1);
    nacc = 0;
    repeat (6) begin
      step(1, 0, 64'h0, 1, 1);
      if (last_acc) nacc++;
    end
    chk("t6_no_fetch", 64'(nacc), 64'd0);
    chk("t6_misalign_sticky", 64'(misalign), 64'd1);
`else
    nacc = 0;
    chk("t6_misalign", 64'(misalign), 64'd0);
    mark = dq.size();
    run_until(1, 1, "t6_deliver");
    chk("t6_first_pc", dq_at(mark), 64'h100);
    chk("t6_no_acc_count", 64'(nacc), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
